// File: rtl/grad_update_sched.sv
// grad_update_sched
//   Playback scheduler for the GPA-FHDO DAC interface. Fetches 4-word gradient
//   frames (x, y, z, z2) from BRAM into shadow registers, then hands each frame
//   to gpa_fhdo_iface with a one-cycle valid_o. Pulses are spaced by a
//   programmable interval. The next frame is fetched while the current SPI
//   transfer runs. Interval underruns and missing busy acknowledgements are
//   reported as sticky flags.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start_i, stop_i   1-cycle control pulses (start ignored while running)
//   n_frames_i        frames to play, sampled on start_i
//   interval_i        cycles between valid_o pulses, sampled on start_i (0 -> 1)
//   mem_en_o/addr_o   BRAM read port; mem_data_i returns 1 cycle later
//   data{x,y,z,z2}_o  frame words presented to the DAC interface
//   valid_o           1-cycle pulse starting an SPI frame
//   busy_i            DAC interface busy
//   running_o         playback in progress
//   done_o            1-cycle pulse when playback ends or is stopped
//   underrun_o        sticky: slot came due while the interface was still busy
//   ack_err_o         sticky: busy_i did not answer a valid_o in time
module grad_update_sched #(
  parameter int ADDR_W  = 13,
  parameter int INT_W   = 16,
  parameter int ACK_TMO = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [ADDR_W-3:0] n_frames_i,
  input  logic [INT_W-1:0]  interval_i,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [23:0]       mem_data_i,
  output logic [23:0]       datax_o,
  output logic [23:0]       datay_o,
  output logic [23:0]       dataz_o,
  output logic [23:0]       dataz2_o,
  output logic              valid_o,
  input  logic              busy_i,
  output logic              running_o,
  output logic              done_o,
  output logic              underrun_o,
  output logic              ack_err_o
);

  localparam int FW    = ADDR_W - 2;
  localparam int ACK_W = $clog2(ACK_TMO + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_SLOT,
    ISSUE,
    WAIT_ACK,
    FINISH
  } state_t;

  state_t            state, state_nx;
  logic [FW-1:0]     frame;
  logic [FW-1:0]     n_frames;
  logic [INT_W-1:0]  ivl_m1;
  logic [INT_W-1:0]  ivl_cnt;
  logic [2:0]        fcnt;
  logic [ACK_W-1:0]  ack_cnt;
  logic              stop_pend;
  logic [23:0]       sh_x, sh_y, sh_z, sh_z2;
  logic              slot_open;
  logic              ack_tmo;
  logic              last_frame;

  // ivl_cnt counts down from interval-1 starting the cycle after ISSUE, so the
  // slot is taken when the count reaches 1 (or has already saturated at 0);
  // this places consecutive ISSUE cycles exactly 'interval' cycles apart.
  assign slot_open  = (ivl_cnt <= INT_W'(1));
  // ack_cnt holds the number of cycles elapsed since valid_o.
  assign ack_tmo    = (ack_cnt >= ACK_W'(ACK_TMO - 1));
  assign last_frame = (frame == n_frames - 1'b1);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start_i) state_nx = (n_frames_i == '0) ? FINISH : FETCH;
      FETCH: begin
        if (stop_i)               state_nx = FINISH;
        else if (fcnt == 3'd4)    state_nx = WAIT_SLOT;
      end
      WAIT_SLOT: begin
        if (stop_i)                      state_nx = FINISH;
        else if (slot_open && !busy_i)   state_nx = ISSUE;
      end
      ISSUE:     state_nx = WAIT_ACK;
      WAIT_ACK: begin
        if (busy_i || ack_tmo)
          state_nx = (last_frame || stop_pend || stop_i) ? FINISH : FETCH;
      end
      FINISH:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_en_o   = (state == FETCH) && !fcnt[2];
    mem_addr_o = mem_en_o ? {frame, fcnt[1:0]} : '0;
    valid_o    = (state == ISSUE);
    running_o  = (state == FETCH) || (state == WAIT_SLOT) ||
                 (state == ISSUE) || (state == WAIT_ACK);
    done_o     = (state == FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      frame      <= '0;
      n_frames   <= '0;
      ivl_m1     <= '0;
      ivl_cnt    <= '0;
      fcnt       <= '0;
      ack_cnt    <= '0;
      stop_pend  <= 1'b0;
      sh_x       <= '0;
      sh_y       <= '0;
      sh_z       <= '0;
      sh_z2      <= '0;
      datax_o    <= '0;
      datay_o    <= '0;
      dataz_o    <= '0;
      dataz2_o   <= '0;
      underrun_o <= 1'b0;
      ack_err_o  <= 1'b0;
    end else begin
      state <= state_nx;
      if (ivl_cnt != '0) ivl_cnt <= ivl_cnt - 1'b1;

      case (state)
        IDLE: begin
          if (start_i) begin
            n_frames   <= n_frames_i;
            ivl_m1     <= (interval_i == '0) ? '0 : interval_i - 1'b1;
            frame      <= '0;
            fcnt       <= '0;
            ivl_cnt    <= '0;
            stop_pend  <= 1'b0;
            underrun_o <= 1'b0;
            ack_err_o  <= 1'b0;
          end
        end
        FETCH: begin
          fcnt <= fcnt + 3'd1;
          case (fcnt)
            3'd1:    sh_x  <= mem_data_i;
            3'd2:    sh_y  <= mem_data_i;
            3'd3:    sh_z  <= mem_data_i;
            3'd4:    sh_z2 <= mem_data_i;
            default: ;
          endcase
        end
        WAIT_SLOT: begin
          if (!stop_i && slot_open && busy_i) underrun_o <= 1'b1;
          // Shadows move to the outputs on the edge entering ISSUE so the
          // words are already present in the cycle valid_o is high.
          if (state_nx == ISSUE) begin
            datax_o  <= sh_x;
            datay_o  <= sh_y;
            dataz_o  <= sh_z;
            dataz2_o <= sh_z2;
          end
        end
        ISSUE: begin
          ivl_cnt <= ivl_m1;
          ack_cnt <= ACK_W'(1);
          if (stop_i) stop_pend <= 1'b1;
        end
        WAIT_ACK: begin
          ack_cnt <= ack_cnt + 1'b1;
          if (stop_i) stop_pend <= 1'b1;
          if (busy_i || ack_tmo) begin
            if (!busy_i) ack_err_o <= 1'b1;
            frame <= frame + 1'b1;
            fcnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_grad_update_sched.sv
module tb_grad_update_sched;

  localparam int ADDR_W  = 13;
  localparam int INT_W   = 16;
  localparam int ACK_TMO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic              stop_i;
  logic [ADDR_W-3:0] n_frames_i;
  logic [INT_W-1:0]  interval_i;
  logic              mem_en_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [23:0]       mem_data_i = '0;
  logic [23:0]       datax_o, datay_o, dataz_o, dataz2_o;
  logic              valid_o;
  logic              busy_i;
  logic              running_o, done_o, underrun_o, ack_err_o;

  always #5 clk = ~clk;

  grad_update_sched #(.ADDR_W(ADDR_W), .INT_W(INT_W), .ACK_TMO(ACK_TMO)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
    .n_frames_i(n_frames_i), .interval_i(interval_i),
    .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .datax_o(datax_o), .datay_o(datay_o), .dataz_o(dataz_o), .dataz2_o(dataz2_o),
    .valid_o(valid_o), .busy_i(busy_i), .running_o(running_o), .done_o(done_o),
    .underrun_o(underrun_o), .ack_err_o(ack_err_o)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] word(input logic [ADDR_W-1:0] a);
    return {11'h5A5, a};
  endfunction

  // BRAM with one cycle read latency
  always @(posedge clk) if (mem_en_o) mem_data_i <= word(mem_addr_o);

  // DAC interface model: busy rises 2 cycles after valid_o, stays high 130 cycles
  int unsigned busy_mode = 0;
  int unsigned tv = 0;
  bit          have_v = 0;
  assign busy_i = (busy_mode == 1) && have_v && (cyc >= tv + 2) && (cyc < tv + 132);

  // Monitor, cleared whenever run_id changes
  int unsigned run_id = 0, mon_id = 0;
  int unsigned v_q[$], rd_q[$], d_q[$], bf_q[$];
  logic [95:0] vd_q[$];
  logic [95:0] prev_data = '0;
  bit          prev_busy = 0, ae_seen = 0, run_bad = 0, data_bad = 0;
  int unsigned ae_cyc = 0;

  always @(negedge clk) begin
    if (mon_id != run_id) begin
      mon_id = run_id;
      v_q.delete(); rd_q.delete(); d_q.delete(); bf_q.delete(); vd_q.delete();
      have_v = 0; prev_busy = 0; ae_seen = 0; run_bad = 0; data_bad = 0;
      prev_data = {datax_o, datay_o, dataz_o, dataz2_o};
    end
    if (mem_en_o) rd_q.push_back(mem_addr_o);
    if (valid_o) begin
      v_q.push_back(cyc);
      vd_q.push_back({datax_o, datay_o, dataz_o, dataz2_o});
      tv = cyc;
      have_v = 1;
      if (!running_o) run_bad = 1;
    end
    if ({datax_o, datay_o, dataz_o, dataz2_o} != prev_data && !valid_o) data_bad = 1;
    prev_data = {datax_o, datay_o, dataz_o, dataz2_o};
    if (prev_busy && !busy_i) bf_q.push_back(cyc);
    prev_busy = busy_i;
    if (done_o) d_q.push_back(cyc);
    if (ack_err_o && !ae_seen) begin
      ae_seen = 1;
      ae_cyc  = cyc;
    end
  end

  int unsigned passed = 0, total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct {
    int unsigned n;
    int unsigned ivl;
    int unsigned mode;        // 1 = iface model, 0 = busy tied low
    int unsigned exp_v;       // valid_o pulses
    int unsigned exp_rd;      // BRAM reads
    int unsigned space;       // required valid spacing, 0 = not checked
    int unsigned done_after;  // done_o cycles after last valid_o
    bit          exp_ur;
    bit          exp_ae;
    bit          chk_bf;      // each later valid must follow busy fall by 1
  } vec_t;

  task automatic start_run(input int unsigned n, input int unsigned ivl,
                           output int unsigned ts);
    n_frames_i = (ADDR_W-2)'(n);
    interval_i = INT_W'(ivl);
    start_i    = 1'b1;
    ts         = cyc;
    @(negedge clk);
    start_i    = 1'b0;
  endtask

  task automatic new_run(input int unsigned mode);
    busy_mode = mode;
    run_id++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_run(input vec_t r, input int unsigned ts);
    logic [95:0] d;
    int unsigned bf;
    chk("valid_count", v_q.size(), r.exp_v);
    chk("read_count", rd_q.size(), r.exp_rd);
    for (int i = 0; i < rd_q.size(); i++) chk("read_addr", rd_q[i], i);
    for (int k = 0; k < vd_q.size(); k++) begin
      d = vd_q[k];
      for (int c = 0; c < 4; c++)
        chk("frame_data", d[95 - 24*c -: 24], word(ADDR_W'(4*k + c)));
    end
    if (v_q.size() > 0) chk("first_valid_latency", v_q[0] - ts, 7);
    if (r.space != 0)
      for (int k = 1; k < v_q.size(); k++) chk("valid_spacing", v_q[k] - v_q[k-1], r.space);
    if (r.chk_bf)
      for (int k = 1; k < v_q.size(); k++) begin
        bf = 0;
        foreach (bf_q[j]) if (bf_q[j] < v_q[k]) bf = bf_q[j];
        chk("issue_after_busy_fall", v_q[k] - bf, 1);
      end
    chk("done_count", d_q.size(), 1);
    if (d_q.size() > 0) begin
      if (r.exp_v == 0) chk("done_latency", d_q[0] - ts, 1);
      else if (v_q.size() > 0) chk("done_after_last_valid", d_q[0] - v_q[v_q.size()-1], r.done_after);
    end
    chk("underrun", underrun_o, r.exp_ur);
    chk("ack_err", ack_err_o, r.exp_ae);
    if (r.exp_ae && v_q.size() > 0) chk("ack_err_delay", ae_seen ? ae_cyc - v_q[0] : 0, 8);
    chk("running_after_done", running_o, 0);
    chk("running_during_valid", run_bad, 0);
    chk("data_stable", data_bad, 0);
  endtask

  task automatic apply(input vec_t r);
    int unsigned ts;
    new_run(r.mode);
    start_run(r.n, r.ivl, ts);
    for (int i = 0; i < 4000 && d_q.size() == 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check_run(r, ts);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t vecs[4];
  vec_t rvec;

  initial begin
    int unsigned ts, sc, tgt;
    rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; n_frames_i = '0; interval_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {mem_en_o, mem_addr_o, datax_o, datay_o, dataz_o, dataz2_o,
                          valid_o, running_o, done_o, underrun_o, ack_err_o}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {mem_en_o, valid_o, running_o, done_o}, 0);

    //          n  ivl mode v  rd space done ur ae bf
    vecs[0] = '{3, 200, 1, 3, 12, 200, 3, 0, 0, 0};
    vecs[1] = '{4,  50, 1, 4, 16,   0, 3, 1, 0, 1};
    vecs[2] = '{2,  20, 0, 2,  8,  20, 8, 0, 1, 0};
    vecs[3] = '{0, 100, 1, 0,  0,   0, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) apply(vecs[i]);

    // stop during WAIT_SLOT of frame 2
    new_run(1);
    start_run(5, 200, ts);
    for (int i = 0; i < 2000 && v_q.size() < 2; i++) @(negedge clk);
    chk("stop_two_valids_seen", v_q.size(), 2);
    tgt = (v_q.size() >= 2) ? v_q[1] + 150 : cyc;
    for (int i = 0; i < 400 && cyc < tgt; i++) @(negedge clk);
    stop_i = 1'b1;
    sc = cyc;
    @(negedge clk);
    stop_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("stop_done_count", d_q.size(), 1);
    if (d_q.size() > 0) chk("stop_done_latency", d_q[0] - sc, 1);
    chk("stop_running", running_o, 0);
    chk("stop_reads", rd_q.size(), 12);
    repeat (250) @(negedge clk);
    chk("stop_valid_count", v_q.size(), 2);
    // stop in IDLE is ignored
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("stop_idle_no_done", d_q.size(), 1);
    chk("stop_idle_running", running_o, 0);

    // reset during FETCH of frame 1
    new_run(1);
    start_run(5, 200, ts);
    for (int i = 0; i < 100 && v_q.size() < 1; i++) @(negedge clk);
    chk("rst_first_valid", v_q.size(), 1);
    tgt = (v_q.size() >= 1) ? v_q[0] + 4 : cyc;
    for (int i = 0; i < 100 && cyc < tgt; i++) @(negedge clk);
    chk("rst_in_fetch", mem_en_o, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_outputs", {mem_en_o, mem_addr_o, datax_o, datay_o, dataz_o, dataz2_o,
                        valid_o, running_o, done_o, underrun_o, ack_err_o}, 0);
    rst = 1'b0;
    rvec = '{1, 5, 1, 1, 4, 0, 3, 0, 0, 0};
    apply(rvec);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
